// File: rtl/spi_periferico_multimodo.sv
// spi_periferico_multimodo
// Register-mapped SPI master supporting all four CPOL/CPHA modes. A host
// programs a control register and a word buffer through one write strobe.
// Setting send starts one CS-framed burst of up to DEPTH words. Each received
// word is written back into the buffer slot its transmit word came from.
//
// Ports
//   clk, rst          system clock; asynchronous active-high reset
//   wr_i              single-cycle host write strobe
//   reg_sel_i         1 = data buffer, 0 = control register
//   addr_i            buffer address for host reads/writes
//   wdata_i           host write data
//   rdata_o           combinational read of buffer[addr_i] or the control register
//   busy_o            high whenever the sequencer is not idle
//   done_o            one-cycle pulse when a burst completes normally
//   sclk_o, mosi_o    SPI clock and data out
//   miso_i            SPI data in (asynchronous to clk; no synchroniser here)
//   cs_n_o            active-low chip selects
module spi_periferico_multimodo #(
  parameter int DATA_W            = 8,
  parameter int DEPTH             = 256,
  parameter int ADDR_W            = $clog2(DEPTH),
  parameter int N_CS              = 2,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic              reg_sel_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [N_CS-1:0]   cs_n_o
);

  localparam int CPH    = CLKS_PER_HALF_BIT;
  localparam int CNT_W  = (CPH > 1) ? $clog2(CPH) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam int NRX_W  = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, STORE, HOLD, DONE} state_t;

  state_t              state_reg;
  logic                send_reg, all_1s_reg, all_0s_reg, cpol_reg, cpha_reg;
  logic [2:0]          cs_sel_reg;
  logic [7:0]          n_tx_end_reg;
  logic [NRX_W-1:0]    n_rx_reg;
  logic [ADDR_W-1:0]   ptr_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [EDGE_W-1:0]   edge_cnt_reg;
  logic [DATA_W-1:0]   tx_sh_reg, rx_sh_reg;
  logic                sclk_reg, mosi_reg, done_reg;
  logic [N_CS-1:0]     cs_n_reg;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                host_ctrl_wr, host_buf_wr, abort;
  logic                half_tick, last_edge, sample_now;
  logic [DATA_W-1:0]   load_word, tx_shifted, rx_next;
  logic [N_CS-1:0]     cs_assert;
  logic [31:0]         ctrl_rd;
  logic                unused_wdata;

  assign host_ctrl_wr = wr_i && !reg_sel_i;
  assign host_buf_wr  = wr_i && reg_sel_i && (state_reg == IDLE);
  assign abort        = host_ctrl_wr && (state_reg != IDLE) && wdata_i[31];

  assign half_tick  = (cnt_reg == CNT_W'(CPH - 1));
  assign last_edge  = (edge_cnt_reg == EDGE_W'(2 * DATA_W - 1));
  // Even edge indices are leading edges. cpha=0 samples on leading edges,
  // cpha=1 on trailing edges, so sampling happens when the two differ.
  assign sample_now = ~edge_cnt_reg[0] ^ cpha_reg;
  assign tx_shifted = tx_sh_reg << 1;
  assign rx_next    = (rx_sh_reg << 1) | DATA_W'(miso_i);

  always_comb begin
    load_word = mem[ptr_reg];
    if (all_1s_reg)      load_word = '1;
    else if (all_0s_reg) load_word = '0;
  end

  // An out-of-range cs_sel matches no line, so the burst runs unselected.
  generate
    for (genvar gi = 0; gi < N_CS; gi++) begin : g_cs
      assign cs_assert[gi] = (cs_sel_reg == 3'(gi));
    end
  endgenerate

  assign ctrl_rd = {7'd0, 9'(n_rx_reg), n_tx_end_reg, cs_sel_reg,
                    cpha_reg, cpol_reg, all_0s_reg, all_1s_reg, send_reg};
  assign rdata_o = reg_sel_i ? 32'(mem[addr_i]) : ctrl_rd;

  assign busy_o       = (state_reg != IDLE);
  assign done_o       = done_reg;
  assign sclk_o       = sclk_reg;
  assign mosi_o       = mosi_reg;
  assign cs_n_o       = cs_n_reg;
  assign unused_wdata = ^wdata_i[30:16];

  // Buffer: host writes only while idle, sequencer writes only in STORE,
  // so the two writers never collide.
  always_ff @(posedge clk) begin
    if (host_buf_wr)
      mem[addr_i] <= wdata_i[DATA_W-1:0];
    else if (state_reg == STORE)
      mem[ptr_reg] <= rx_sh_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      send_reg     <= 1'b0;
      all_1s_reg   <= 1'b0;
      all_0s_reg   <= 1'b0;
      cpol_reg     <= 1'b0;
      cpha_reg     <= 1'b0;
      cs_sel_reg   <= '0;
      n_tx_end_reg <= '0;
      n_rx_reg     <= '0;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      edge_cnt_reg <= '0;
      tx_sh_reg    <= '0;
      rx_sh_reg    <= '0;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      cs_n_reg     <= '1;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        state_reg <= IDLE;
        send_reg  <= 1'b0;
        cs_n_reg  <= '1;
        sclk_reg  <= cpol_reg;
        mosi_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            cs_n_reg <= '1;
            mosi_reg <= 1'b0;
            if (host_ctrl_wr) begin
              send_reg     <= wdata_i[0];
              all_1s_reg   <= wdata_i[1];
              all_0s_reg   <= wdata_i[2];
              cpol_reg     <= wdata_i[3];
              cpha_reg     <= wdata_i[4];
              cs_sel_reg   <= wdata_i[7:5];
              n_tx_end_reg <= wdata_i[15:8];
              // SCLK idles at the new polarity without a cycle of lag.
              sclk_reg     <= wdata_i[3];
            end else begin
              sclk_reg <= cpol_reg;
            end
            if (send_reg) begin
              n_rx_reg  <= '0;
              ptr_reg   <= '0;
              cnt_reg   <= '0;
              cs_n_reg  <= ~cs_assert;
              state_reg <= SETUP;
            end
          end
          SETUP: begin
            if (half_tick) begin
              cnt_reg   <= '0;
              state_reg <= LOAD;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          LOAD: begin
            tx_sh_reg    <= load_word;
            if (!cpha_reg) mosi_reg <= load_word[DATA_W-1];
            cnt_reg      <= '0;
            edge_cnt_reg <= '0;
            state_reg    <= SHIFT;
          end
          SHIFT: begin
            if (half_tick) begin
              cnt_reg      <= '0;
              sclk_reg     <= ~sclk_reg;
              edge_cnt_reg <= edge_cnt_reg + EDGE_W'(1);
              if (sample_now) begin
                rx_sh_reg <= rx_next;
              end else if (cpha_reg) begin
                mosi_reg  <= tx_sh_reg[DATA_W-1];
                tx_sh_reg <= tx_shifted;
              end else if (!last_edge) begin
                // cpha=0: MSB went out in LOAD, trailing edges advance the rest.
                mosi_reg  <= tx_shifted[DATA_W-1];
                tx_sh_reg <= tx_shifted;
              end
              // An even edge count returns SCLK to cpol on the final edge.
              if (last_edge) state_reg <= STORE;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          STORE: begin
            if (n_rx_reg != NRX_W'(DEPTH)) n_rx_reg <= n_rx_reg + NRX_W'(1);
            if (ptr_reg == n_tx_end_reg[ADDR_W-1:0]) begin
              cnt_reg   <= '0;
              state_reg <= HOLD;
            end else begin
              ptr_reg   <= ptr_reg + ADDR_W'(1);
              state_reg <= LOAD;
            end
          end
          HOLD: begin
            if (half_tick) begin
              cnt_reg   <= '0;
              cs_n_reg  <= '1;
              send_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          DONE: begin
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_periferico_multimodo.sv
// Self-checking bench for spi_periferico_multimodo. Buffer contents and burst
// modes are randomised; a reference model derives the expected MOSI words,
// written-back words, burst length, CS pattern and n_rx from the block rules.
module tb_spi_periferico_multimodo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int N_CS   = 2;
  localparam int CPH    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr;
  logic              reg_sel;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              busy, done, sclk, mosi, miso;
  logic [N_CS-1:0]   cs_n;
  logic              miso_inv;

  spi_periferico_multimodo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .N_CS(N_CS), .CLKS_PER_HALF_BIT(CPH)
  ) dut (
    .clk(clk), .rst(rst), .wr_i(wr), .reg_sel_i(reg_sel), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .busy_o(busy), .done_o(done),
    .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso), .cs_n_o(cs_n)
  );

  always #5 clk = ~clk;

  // Loopback, optionally inverted.
  assign miso = mosi ^ miso_inv;

  int vectors     = 0;
  int miscompares = 0;
  int done_total  = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_tx_q [$];
  logic              bitq [$];
  logic              mon_rise = 1'b1;

  // Record MOSI at each SPI sampling edge of the current mode.
  always @(posedge sclk) if (busy && mon_rise)  bitq.push_back(mosi);
  always @(negedge sclk) if (busy && !mon_rise) bitq.push_back(mosi);
  always @(negedge clk)  if (done) done_total++;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic sel, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; reg_sel = sel; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic host_read(input logic sel, input logic [ADDR_W-1:0] a, output logic [31:0] d);
    @(negedge clk);
    reg_sel = sel; addr = a;
    #1 d = rdata;
  endtask

  task automatic fill(input int a, input logic [DATA_W-1:0] d);
    host_write(1'b1, ADDR_W'(a), 32'(d));
    model_mem[a] = d;
  endtask

  task automatic run_burst(input logic [15:0] ctrl, input logic inv, input string tag);
    logic              cpol, cpha, a1, a0;
    int                k, cs_sel, exp_lat, busy_cnt, dn, finished;
    logic [N_CS-1:0]   cs_exp, cs_and, cs_or;
    logic [DATA_W-1:0] tx, got;
    logic [31:0]       rd;
    cpol   = ctrl[3];
    cpha   = ctrl[4];
    a1     = ctrl[1];
    a0     = ctrl[2];
    cs_sel = int'(ctrl[7:5]);
    k      = int'(ctrl[15:8]) + 1;
    cs_exp = '1;
    if (cs_sel < N_CS) cs_exp[cs_sel] = 1'b0;
    exp_lat = CPH + k * (2 + 2 * DATA_W * CPH) + CPH + 1;
    exp_tx_q.delete();
    for (int i = 0; i < k; i++) begin
      tx = a1 ? '1 : (a0 ? '0 : model_mem[i]);
      exp_tx_q.push_back(tx);
      model_mem[i] = inv ? ~tx : tx;
    end
    miso_inv = inv;
    mon_rise = (cpol == cpha);
    bitq.delete();

    host_write(1'b0, '0, {16'h0, ctrl});
    check({tag, "_idle_sclk"}, 32'(sclk), 32'(cpol));

    busy_cnt = 0; dn = 0; finished = 0; cs_and = '1; cs_or = '0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (done) dn++;
        else begin
          cs_and &= cs_n;
          cs_or  |= cs_n;
        end
      end else if (busy_cnt > 0) begin
        finished = 1;
        break;
      end
    end
    check({tag, "_finished"}, 32'(finished), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, "_done_pulses"}, 32'(dn), 32'd1);
    check({tag, "_cs_low_and"}, 32'(cs_and), 32'(cs_exp));
    check({tag, "_cs_low_or"}, 32'(cs_or), 32'(cs_exp));
    check({tag, "_end_sclk"}, 32'(sclk), 32'(cpol));
    check({tag, "_mosi_bits"}, 32'(bitq.size()), 32'(k * DATA_W));
    if (bitq.size() >= k * DATA_W) begin
      for (int w = 0; w < k; w++) begin
        got = '0;
        for (int b = 0; b < DATA_W; b++) got = (got << 1) | DATA_W'(bitq[w * DATA_W + b]);
        check($sformatf("%s_mosi_word%0d", tag, w), 32'(got), 32'(exp_tx_q[w]));
      end
    end
    for (int w = 0; w < k; w++) begin
      host_read(1'b1, ADDR_W'(w), rd);
      check($sformatf("%s_buf%0d", tag, w), rd, 32'(model_mem[w]));
    end
    host_read(1'b0, '0, rd);
    check({tag, "_n_rx"}, 32'(rd[24:16]), 32'(k));
    check({tag, "_send_clr"}, 32'(rd[0]), 32'd0);
    $display("burst %s: %0d words, %0d busy cycles", tag, k, busy_cnt);
  endtask

  initial begin
    logic [31:0] rd;
    int          k, dbefore;
    logic [15:0] ctrl;
    logic [DATA_W-1:0] orig0, orig1;

    rst = 1'b1; wr = 1'b0; reg_sel = 1'b0; addr = '0; wdata = '0; miso_inv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_cs", 32'(cs_n), 32'h3);
    host_read(1'b0, '0, rd);
    check("rst_ctrl", rd, 32'h0);

    // Mode 0 loopback, single word.
    fill(0, 8'hA5);
    run_burst(16'h0001, 1'b0, "t1");

    // Mode 3, inverted loopback, three words.
    fill(0, 8'h01); fill(1, 8'h80); fill(2, 8'h3C);
    run_burst(16'h0219, 1'b1, "t2");

    // all_1s beats all_0s; cs_sel = 1.
    fill(0, 8'hFF);
    run_burst(16'h0027, 1'b0, "t3");

    // Randomised modes, lengths, fill patterns and loopback polarity.
    for (int r = 0; r < 5; r++) begin
      k = int'($urandom_range(1, 5));
      for (int i = 0; i < k; i++) fill(i, DATA_W'($urandom));
      ctrl = {8'(k - 1), 3'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 3) == 0), 1'b1};
      run_burst(ctrl, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    // Out-of-range chip select: burst runs with no CS asserted.
    fill(0, DATA_W'($urandom)); fill(1, DATA_W'($urandom));
    run_burst(16'h01A1, 1'b0, "t6");

    // Full-depth burst: n_tx_end = 255 wraps to 256 words.
    for (int i = 0; i < DEPTH; i++) fill(i, DATA_W'($urandom));
    run_burst(16'hFF01, 1'b1, "wrap");

    // Writes while busy are ignored; abort mid word 2 of 4.
    miso_inv = 1'b0;
    for (int i = 0; i < 4; i++) fill(i, DATA_W'($urandom));
    orig0 = model_mem[0];
    orig1 = model_mem[1];
    dbefore = done_total;
    host_write(1'b0, '0, 32'h0000_0301);
    repeat (5) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    host_write(1'b1, '0, 32'(~orig0));
    host_write(1'b0, '0, 32'h0000_0000);
    repeat (38) @(negedge clk);
    check("abort_still_busy", 32'(busy), 32'd1);
    host_write(1'b0, '0, 32'h8000_0000);
    check("abort_cs", 32'(cs_n), 32'h3);
    check("abort_busy_low", 32'(busy), 32'd0);
    check("abort_sclk", 32'(sclk), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_total), 32'(dbefore));
    host_read(1'b0, '0, rd);
    check("abort_ctrl", rd, 32'h0001_0300);
    host_read(1'b1, 8'd0, rd);
    check("abort_buf0", rd, 32'(orig0));
    host_read(1'b1, 8'd1, rd);
    check("abort_buf1", rd, 32'(orig1));
    $display("abort step done");

    // Asynchronous reset mid-SHIFT.
    fill(0, DATA_W'($urandom));
    host_write(1'b0, '0, 32'h0000_0001);
    repeat (12) @(negedge clk);
    check("rstmid_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_cs", 32'(cs_n), 32'h3);
    check("rstmid_sclk", 32'(sclk), 32'd0);
    check("rstmid_busy_low", 32'(busy), 32'd0);
    reg_sel = 1'b0;
    #1;
    check("rstmid_ctrl", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    host_read(1'b1, 8'd0, rd);
    check("rstmid_buf0", rd, 32'(model_mem[0]));
    host_read(1'b1, 8'd2, rd);
    check("rstmid_buf2", rd, 32'(model_mem[2]));
    $display("reset step done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_periferico_multimodo.md
Name: spi_periferico_multimodo

Overview:
Register-mapped SPI master peripheral. It supports a parametrised word width, buffer depth and chip-select count, plus the four CPOL/CPHA modes. A host writes a control register and a data buffer through a single write strobe. On `send`, the block shifts up to DEPTH words out of the buffer in one CS-framed burst and writes each received word back into the same buffer slot. It sits between the board-level switch/button front end and the external SPI pins, in the same position as the current single-mode SPI interface.

Parameters:
DATA_W, 8, bits per SPI word (1..32), MSB first.
DEPTH, 256, data buffer words; power of 2, ≤256.
ADDR_W, $clog2(DEPTH), buffer address width (derived; do not override).
N_CS, 2, number of chip-select outputs (1..8).
CLKS_PER_HALF_BIT, 2, clk cycles per SCLK half period (≥1); written CPH below.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
wr_i  in  1  single-cycle host write strobe.
reg_sel_i  in  1  1 = data buffer, 0 = control register.
addr_i  in  ADDR_W  buffer address for reads and writes.
wdata_i  in  32  write data.
rdata_o  out  32  combinational read: buffer[addr_i] zero-extended, or the control register.
busy_o  out  1  high in every FSM state except IDLE.
done_o  out  1  one-cycle pulse on normal burst completion.
sclk_o  out  1  SPI clock.
mosi_o  out  1  SPI data out.
miso_i  in  1  SPI data in (no synchroniser here).
cs_n_o  out  N_CS  active-low chip selects.

Behaviour:
- Control register layout:
  - [0] send
  - [1] all_1s
  - [2] all_0s
  - [3] cpol
  - [4] cpha
  - [7:5] cs_sel
  - [15:8] n_tx_end (words − 1; only ADDR_W LSBs used)
  - [24:16] n_rx (read-only)
  - [31] abort (write-only, reads 0)
  - All other bits read 0.
- Reset: control register = 0, FSM = IDLE, busy_o = 0, done_o = 0, sclk_o = 0, mosi_o = 0, cs_n_o = all 1s. Buffer contents are not reset.
- Writes when idle:
  - reg_sel_i = 0: bits [15:0] are loaded; n_rx is unchanged.
  - reg_sel_i = 1: buffer[addr_i] ← wdata_i[DATA_W-1:0].
- Writes while busy:
  - Data-buffer writes are ignored.
  - Control writes are ignored unless wdata_i[31] = 1 (abort).
- FSM sequence: IDLE → SETUP → LOAD → SHIFT → STORE → (LOAD | HOLD) → DONE → IDLE.
- IDLE:
  - sclk_o = cpol, mosi_o = 0, cs_n_o = all 1s.
  - The cycle after send is seen as 1: clear n_rx and the word pointer, then go to SETUP.
- SETUP: cs_n_o[cs_sel] = 0 for CPH cycles, sclk_o held at cpol. If cs_sel ≥ N_CS, no CS is asserted but the burst still runs.
- LOAD (1 cycle):
  - TX word = all 1s if all_1s; else 0 if all_0s; else buffer[ptr]. all_1s has priority.
  - When cpha = 0, mosi_o = TX MSB.
- SHIFT: 2·DATA_W SCLK edges, each CPH cycles apart; first edge is leading (cpol → ~cpol).
  - cpha = 0: sample miso_i on leading edges, drive the next bit on trailing edges.
  - cpha = 1: drive a bit on leading edges, sample on trailing edges.
  - sclk_o ends at cpol.
- STORE (1 cycle):
  - buffer[ptr] ← RX word; n_rx += 1, saturating at DEPTH.
  - If ptr == n_tx_end go to HOLD; else ptr += 1 and go to LOAD. CS stays low between words.
- HOLD: CS low for CPH cycles.
- DONE (1 cycle): cs_n_o all 1s, send ← 0, done_o = 1, busy_o still 1.
- Burst latency, k words: CPH + k·(2 + 2·DATA_W·CPH) + CPH + 1 busy cycles. Example: k = 1, CPH = 2, DATA_W = 8 gives 39.
- Abort:
  - Next cycle: FSM = IDLE, cs_n_o all 1s, sclk_o = cpol, send ← 0, no done_o.
  - n_rx keeps the count of completed words; a partially shifted word is discarded.
- Reset mid-burst: immediate return to reset values; buffer untouched.
- n_tx_end ≥ DEPTH−1 wraps the pointer within ADDR_W; with DEPTH = 256, n_tx_end = 255 transfers 256 words and n_rx = 256.

Test Plan:
1. Loopback miso_i = mosi_o, mode 0: buffer[0] = 0xA5, ctrl = 0x0001 → SCLK idles low, 8 pulses, busy_o for 39 cycles, done_o one pulse; then buffer[0] = 0xA5, n_rx = 1.
2. Inverted loopback miso_i = ~mosi_o, mode 3, 3 words (0x01, 0x80, 0x3C), ctrl = 0x0219 → SCLK idles high; buffer becomes 0xFE, 0x7F, 0xC3; cs_n_o[0] stays low across all three words; n_rx = 3.
3. all_1s and all_0s both set, cs_sel = 1, ctrl = 0x0027 → mosi_o = 1 on every bit, cs_n_o = 2'b01 during the burst, buffer[0] unchanged.
4. While busy: data write to addr 0 and ctrl write 0x0000 → both ignored; then abort write 0x80000000 mid-word 2 of 4 → next cycle cs_n_o = 2'b11, busy_o = 0, no done_o, n_rx = 1.
5. Assert rst mid-SHIFT → same cycle cs_n_o = all 1s, sclk_o = 0, ctrl reads 0; buffer contents retained.
6. cs_sel = 5 with N_CS = 2 → no CS asserted, burst completes, done_o pulses, n_rx = n_tx_end + 1.
